// File: rtl/display_tx_streamer.sv
// display_tx_streamer: streams the ASCII display word, CR first then chars MSB-first, over a valid/ready byte link.
// Optional periodic resend of an unchanged display when DISPLAY_STREAM_REFRESH_EN is defined.
module display_tx_streamer #(
    parameter int unsigned NUM_CHARS = 5,
    parameter logic [7:0]  LEAD_CHAR = 8'h0D
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CHARS*8-1:0] display,
    input  logic                   send_req,
    input  logic                   tx_ready,
    output logic                   tx_valid,
    output logic [7:0]             tx_data,
    output logic                   busy,
    output logic                   frame_done
);
    localparam int unsigned      IDX_W    = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHARS - 1);

    typedef enum logic [1:0] {IDLE, SEND_LEAD, SEND_CHARS} state_t;

    state_t                 state_q, state_d;
    logic [NUM_CHARS*8-1:0] snapshot_q, snapshot_d;
    logic [NUM_CHARS*8-1:0] last_sent_q, last_sent_d;
    logic                   force_q, force_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   tx_valid_d, busy_d, frame_done_d;
    logic [7:0]             tx_data_d;
    logic                   xfer, start, refresh_hit;

    // Char 0 lives in the most significant byte of the word.
    function automatic logic [7:0] char_at(input logic [NUM_CHARS*8-1:0] word,
                                           input logic [IDX_W-1:0]       i);
        logic [7:0] c;
        c = '0;
        for (int unsigned k = 0; k < NUM_CHARS; k++) begin
            if (i == IDX_W'(k)) c = word[(NUM_CHARS-1-k)*8 +: 8];
        end
        return c;
    endfunction

    assign xfer  = tx_valid && tx_ready;
    assign start = (state_q == IDLE) && (force_q || send_req || (display != last_sent_q));

`ifdef DISPLAY_STREAM_REFRESH_EN
    localparam logic [23:0] REFRESH_PERIOD = 24'd10_000_000;
    logic [23:0] refresh_cnt;

    assign refresh_hit = (state_q == IDLE) && (refresh_cnt == REFRESH_PERIOD);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
        end else if (state_q == IDLE) begin
            if (start || refresh_hit) refresh_cnt <= '0;
            else                      refresh_cnt <= refresh_cnt + 24'd1;
        end
    end
`else
    assign refresh_hit = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        snapshot_d   = snapshot_q;
        last_sent_d  = last_sent_q;
        force_d      = force_q;
        idx_d        = idx_q;
        tx_valid_d   = tx_valid;
        tx_data_d    = tx_data;
        busy_d       = busy;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = SEND_LEAD;
                    snapshot_d  = display;
                    last_sent_d = display;
                    force_d     = 1'b0;
                    idx_d       = '0;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = LEAD_CHAR;
                    busy_d      = 1'b1;
                end else if (refresh_hit) begin
                    force_d = 1'b1;
                end
            end
            SEND_LEAD: begin
                if (send_req) force_d = 1'b1;
                if (xfer) begin
                    state_d   = SEND_CHARS;
                    idx_d     = '0;
                    tx_data_d = char_at(snapshot_q, '0);
                end
            end
            SEND_CHARS: begin
                if (send_req) force_d = 1'b1;
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        state_d      = IDLE;
                        tx_valid_d   = 1'b0;
                        busy_d       = 1'b0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d     = idx_q + IDX_W'(1);
                        tx_data_d = char_at(snapshot_q, idx_d);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            snapshot_q  <= '0;
            last_sent_q <= '0;
            force_q     <= 1'b1;
            idx_q       <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= 8'h00;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            snapshot_q  <= snapshot_d;
            last_sent_q <= last_sent_d;
            force_q     <= force_d;
            idx_q       <= idx_d;
            tx_valid    <= tx_valid_d;
            tx_data     <= tx_data_d;
            busy        <= busy_d;
            frame_done  <= frame_done_d;
        end
    end

endmodule
